uart_rx_mmio: RTL and testbench
===============================

# uart_rx_mmio

Memory-mapped UART receiver: the receive counterpart of the CPU's UART transmit path. It samples the asynchronous `rx_pin` as 8N1 frames, pushes good bytes into a receive FIFO, and exposes DATA/STATUS registers on the system bus so firmware can poll and pop bytes. `rx_irq` is a level output, available to a future interrupt controller.

## Interface
- `CLK_FREQ`, 50000000: clock frequency in Hz.
- `BAUD_RATE`, 115200: line rate. `BIT_CYCLES = CLK_FREQ/BAUD_RATE`, integer division, giving 434 at the defaults. `HALF = BIT_CYCLES/2`.
- `FIFO_DEPTH`, 16: receive FIFO entries. Must be a power of 2, minimum 2.
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous and active-high.
- `rx_pin`  in  1  serial input; idles high; asynchronous to `clk`.
- `bus_addr`  in  4  byte offset within the peripheral. Bit 2 selects the register: 0 = DATA, 1 = STATUS.
- `bus_ren`  in  1  single-cycle read strobe. Only a DATA read has side effects.
- `bus_wen`  in  1  single-cycle write strobe.
- `bus_wdata`  in  32  write data; only meaningful for STATUS.
- `mmio_rdata`  out  32  combinational read data for the selected register.
- `rx_irq`  out  1  high while the FIFO is non-empty.

## Operation
- **Input synchronizer**
  - Two flops on `rx_pin`, both reset to 1.
  - All FSM decisions use the synchronized bit `rx_s`.
- **Receive FSM states**: IDLE, START, DATA, STOP, BREAK. A bit counter `cnt` and bit index `idx` (0..7) track progress.
  - IDLE: when `rx_s`=0, go to START with `cnt`=0.
  - START: at `cnt`=HALF-1, sample `rx_s`.
    - 1: glitch; return to IDLE.
    - 0: go to DATA with `cnt`=0 and `idx`=0.
  - DATA: at `cnt`=BIT_CYCLES-1, sample `rx_s` into the shift register (LSB first) and reset `cnt`. After `idx`=7 is sampled, go to STOP.
  - STOP: at `cnt`=BIT_CYCLES-1, sample `rx_s`.
    - 1: push the byte if the FIFO is not full; if full, drop the byte and set sticky OVR. Go to IDLE.
    - 0: discard the byte, set sticky FERR, go to BREAK.
  - BREAK: wait for `rx_s`=1, then go to IDLE. This prevents a held-low line from being taken as back-to-back start bits.
- **FIFO**
  - Read and write pointers are `log2(FIFO_DEPTH)+1` bits wide and wrap naturally.
  - Empty when the pointers are equal; full when the MSBs differ and the remaining bits are equal.
  - Count = write pointer - read pointer.
- **DATA register (offset 0x0)**
  - Reads `{24'b0, head_byte}` when the FIFO is non-empty, otherwise 0.
  - `bus_ren` with address bit 2 = 0 pops one entry at the next edge.
  - A pop while empty has no effect.
- **STATUS register (offset 0x4)**
  - Bit 0 VALID (FIFO non-empty), bit 1 FULL, bit 2 OVR, bit 3 FERR.
  - Bits [15:8] hold the count, zero-extended. All other bits read 0.
  - Writing STATUS with `bus_wdata[2]`=1 clears OVR; `bus_wdata[3]`=1 clears FERR. This is write-1-to-clear.
- Writes to DATA are ignored.

## Timing
- **Reset values**
  - FSM in IDLE, `cnt`=0, `idx`=0, shift register 0.
  - FIFO empty, pointers 0, OVR and FERR cleared, synchronizer flops 1.
  - Outputs: `rx_irq`=0; `mmio_rdata`=0 for both registers.
  - Asserting reset mid-frame aborts the frame immediately; no push occurs.
- **Byte latency**
  - The push happens on the STOP sample edge, which is HALF + 9·BIT_CYCLES cycles after IDLE first sees `rx_s`=0.
  - The synchronizer adds 2 cycles of input delay.
  - VALID and `rx_irq` go high the cycle after the push.
- **Pop**: `mmio_rdata` shows the next head entry, or 0, in the cycle after the `bus_ren` edge.
- **Simultaneous events**
  - Push and pop in the same cycle: both take effect and the count is unchanged.
  - When the FIFO is full, a same-cycle pop makes room, so the push succeeds and OVR is not set.
  - A set event and a W1C clear of the same bit in the same cycle: set wins.
- Sampling lands mid-bit to within ±1 cycle. Rate tolerance is determined by the integer rounding of BIT_CYCLES; no fractional correction is applied.

## Test plan
Bench parameters: CLK_FREQ=1600000, BAUD_RATE=100000, giving BIT_CYCLES=16 and HALF=8.

1. Drive frame 0x55 with a good stop bit → VALID=1 and `rx_irq`=1 one cycle after the stop sample; DATA read returns 0x00000055; after the pop, STATUS=0x00000000.
2. Drive a 4-cycle low glitch on an idle line → FSM returns to IDLE from START; no push; STATUS stays 0.
3. Send 17 frames 0x00..0x10 with no reads → STATUS=0x00001007 (count 16, FULL, OVR). Popping 16 times returns 0x00..0x0F in order; 0x10 is lost.
4. Send frame 0xA3 with the stop bit held low for 3 bit-times, then release, then send 0x3C → FERR=1 and only 0x3C is queued. Writing 0x8 to STATUS clears FERR.
5. Time a push to coincide with a pop on a full FIFO → count stays 16 and OVR stays 0. Align a FERR set with a W1C clear → FERR reads 1.
6. Assert `rst` during DATA of frame 0xFF → after release, FIFO empty and STATUS=0; a following 0x81 frame is received correctly.

Source files
------------

// File: rtl/uart_rx_mmio.sv
// Memory-mapped 8N1 UART receiver with a receive FIFO and DATA/STATUS registers.
// rx_irq is a level that stays high while any received byte is waiting.
module uart_rx_mmio #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD_RATE  = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_pin,
  input  logic [3:0]  bus_addr,
  input  logic        bus_ren,
  input  logic        bus_wen,
  input  logic [31:0] bus_wdata,
  output logic [31:0] mmio_rdata,
  output logic        rx_irq
);

  localparam int BIT_CYCLES = CLK_FREQ / BAUD_RATE;
  localparam int HALF       = BIT_CYCLES / 2;
  localparam int CW         = $clog2(BIT_CYCLES);
  localparam int AW         = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
  localparam logic [CW-1:0] BIT_M1  = CW'(BIT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  logic          sync1_q, sync2_q;
  logic          rx_s;
  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    idx_q;
  logic [7:0]    shift_q;
  logic [AW:0]   wr_ptr_q, rd_ptr_q;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic          ovr_q, ovr_d;
  logic          ferr_q, ferr_d;

  logic          empty_s, full_s, pop_s, push_s, stop_tick_s, clr_s;
  logic [AW:0]   count_s;
  logic [31:0]   status_s;
  logic          unused_s;

  assign rx_s     = sync2_q;
  assign rx_irq   = ~empty_s;
  assign unused_s = ^{bus_addr[3], bus_addr[1:0], bus_wdata[31:4], bus_wdata[1:0]};

  // Two-flop synchronizer for the asynchronous serial line
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rx_pin;
      sync2_q <= sync1_q;
    end
  end

  // Frame receiver: start validation at half bit, then whole-bit sampling
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      shift_q <= 8'h00;
    end else begin
      case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          if (!rx_s) state_q <= S_START;
          else       state_q <= S_IDLE;
        end
        S_START: begin
          if (cnt_q == HALF_M1) begin
            cnt_q   <= '0;
            idx_q   <= 3'd0;
            state_q <= rx_s ? S_IDLE : S_DATA;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_DATA: begin
          if (cnt_q == BIT_M1) begin
            cnt_q   <= '0;
            shift_q <= {rx_s, shift_q[7:1]};
            idx_q   <= idx_q + 3'd1;
            if (idx_q == 3'd7) state_q <= S_STOP;
            else               state_q <= S_DATA;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_STOP: begin
          if (cnt_q == BIT_M1) begin
            cnt_q   <= '0;
            state_q <= rx_s ? S_IDLE : S_BREAK;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_BREAK: begin
          cnt_q <= '0;
          if (rx_s) state_q <= S_IDLE;
          else      state_q <= S_BREAK;
        end
        default: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // FIFO flags, push/pop qualification and sticky error next-state (set beats clear)
  always_comb begin
    count_s     = wr_ptr_q - rd_ptr_q;
    empty_s     = (wr_ptr_q == rd_ptr_q);
    full_s      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    pop_s       = bus_ren && !bus_addr[2] && !empty_s;
    stop_tick_s = (state_q == S_STOP) && (cnt_q == BIT_M1);
    push_s      = stop_tick_s && rx_s && (!full_s || pop_s);
    clr_s       = bus_wen && bus_addr[2];
    ovr_d       = ovr_q;
    ferr_d      = ferr_q;
    if (clr_s && bus_wdata[2]) ovr_d = 1'b0;
    else                       ovr_d = ovr_q;
    if (clr_s && bus_wdata[3]) ferr_d = 1'b0;
    else                       ferr_d = ferr_q;
    if (stop_tick_s && rx_s && full_s && !pop_s) ovr_d = 1'b1;
    else                                         ovr_d = ovr_d;
    if (stop_tick_s && !rx_s) ferr_d = 1'b1;
    else                      ferr_d = ferr_d;
  end

  // FIFO pointers and sticky status bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovr_q    <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      if (push_s) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      else        wr_ptr_q <= wr_ptr_q;
      if (pop_s)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
      else        rd_ptr_q <= rd_ptr_q;
      ovr_q  <= ovr_d;
      ferr_q <= ferr_d;
    end
  end

  // FIFO storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (push_s) mem_q[wr_ptr_q[AW-1:0]] <= shift_q;
  end

  // Register read mux
  always_comb begin
    status_s   = {16'h0000, 8'(count_s), 4'h0, ferr_q, ovr_q, full_s, ~empty_s};
    mmio_rdata = 32'h0000_0000;
    if (bus_addr[2])  mmio_rdata = status_s;
    else if (empty_s) mmio_rdata = 32'h0000_0000;
    else              mmio_rdata = {24'h00_0000, mem_q[rd_ptr_q[AW-1:0]]};
  end

endmodule

// File: tb/tb_uart_rx_mmio.sv
// Directed bench for uart_rx_mmio at BIT_CYCLES=16, HALF=8.
module tb_uart_rx_mmio;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_pin;
  logic [3:0]  bus_addr;
  logic        bus_ren;
  logic        bus_wen;
  logic [31:0] bus_wdata;
  logic [31:0] mmio_rdata;
  logic        rx_irq;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] v;

  uart_rx_mmio #(.CLK_FREQ(1600000), .BAUD_RATE(100000), .FIFO_DEPTH(16)) dut (
    .clk(clk), .rst(rst), .rx_pin(rx_pin), .bus_addr(bus_addr), .bus_ren(bus_ren),
    .bus_wen(bus_wen), .bus_wdata(bus_wdata), .mmio_rdata(mmio_rdata), .rx_irq(rx_irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] val);
    bus_addr = a;
    #1;
    val = mmio_rdata;
  endtask

  task automatic pop_check(input string tag, input logic [31:0] exp);
    logic [31:0] d;
    rd(4'h0, d);
    check(tag, d, exp);
    bus_ren = 1'b1;
    tick(1);
    bus_ren = 1'b0;
  endtask

  task automatic wr_status(input logic [31:0] d);
    bus_addr  = 4'h4;
    bus_wdata = d;
    bus_wen   = 1'b1;
    tick(1);
    bus_wen   = 1'b0;
  endtask

  // start bit plus eight data bits, LSB first; leaves the line at the last data bit
  task automatic send_sd(input logic [7:0] b);
    rx_pin = 1'b0;
    tick(16);
    for (int i = 0; i < 8; i++) begin
      rx_pin = b[i];
      tick(16);
    end
  endtask

  task automatic send_frame(input logic [7:0] b);
    send_sd(b);
    rx_pin = 1'b1;
    tick(20);
  endtask

  initial begin
    rst = 1'b1; rx_pin = 1'b1; bus_addr = 4'h0; bus_ren = 1'b0;
    bus_wen = 1'b0; bus_wdata = 32'h0;
    tick(3);
    rst = 1'b0;
    tick(2);

    check("reset_irq", {31'h0, rx_irq}, 32'h0);
    rd(4'h0, v); check("reset_data", v, 32'h0);
    rd(4'h4, v); check("reset_status", v, 32'h0);

    // 1: single good frame with exact push timing
    send_sd(8'h55);
    rx_pin = 1'b1;
    tick(10);
    check("t1_irq_before_push", {31'h0, rx_irq}, 32'h0);
    tick(1);
    check("t1_irq_after_push", {31'h0, rx_irq}, 32'h1);
    rd(4'h4, v); check("t1_status_valid", v, 32'h0000_0101);
    tick(8);
    pop_check("t1_data", 32'h0000_0055);
    rd(4'h4, v); check("t1_status_after_pop", v, 32'h0);
    rd(4'h0, v); check("t1_data_empty", v, 32'h0);

    // 2: short low glitch is rejected
    rx_pin = 1'b0;
    tick(4);
    rx_pin = 1'b1;
    tick(40);
    rd(4'h4, v); check("t2_glitch_status", v, 32'h0);

    // 3: overflow
    for (int i = 0; i < 17; i++) send_frame(8'(i));
    rd(4'h4, v); check("t3_status_full_ovr", v, 32'h0000_1007);
    for (int i = 0; i < 16; i++) pop_check($sformatf("t3_pop_%0d", i), 32'(i));
    rd(4'h4, v); check("t3_status_ovr_only", v, 32'h0000_0004);
    wr_status(32'h4);
    rd(4'h4, v); check("t3_ovr_cleared", v, 32'h0);

    // 4: framing error with held-low line, then a good frame
    send_sd(8'hA3);
    rx_pin = 1'b0;
    tick(48);
    rx_pin = 1'b1;
    tick(10);
    send_frame(8'h3C);
    rd(4'h4, v); check("t4_status_ferr", v, 32'h0000_0109);
    pop_check("t4_data", 32'h0000_003C);
    rd(4'h4, v); check("t4_status_ferr_only", v, 32'h0000_0008);
    wr_status(32'h8);
    rd(4'h4, v); check("t4_ferr_cleared", v, 32'h0);
    // writes to DATA are ignored
    bus_addr = 4'h0; bus_wdata = 32'hFFFF_FFFF; bus_wen = 1'b1;
    tick(1);
    bus_wen = 1'b0;
    rd(4'h4, v); check("t4_data_write_ignored", v, 32'h0);

    // 5a: push coincides with pop on a full FIFO
    for (int i = 0; i < 16; i++) send_frame(8'(8'h20 + i));
    rd(4'h4, v); check("t5_full_before", v, 32'h0000_1003);
    send_sd(8'h30);
    rx_pin = 1'b1;
    tick(10);
    bus_addr = 4'h0;
    bus_ren  = 1'b1;
    #1;
    check("t5_head_at_pop", mmio_rdata, 32'h0000_0020);
    tick(1);
    bus_ren = 1'b0;
    rd(4'h4, v); check("t5_full_no_ovr", v, 32'h0000_1003);
    tick(9);
    for (int i = 0; i < 16; i++) pop_check($sformatf("t5_pop_%0d", i), 32'(8'h21 + i));
    rd(4'h4, v); check("t5_status_empty", v, 32'h0);

    // 5b: FERR set and W1C clear in the same cycle
    send_sd(8'h5A);
    rx_pin = 1'b0;
    tick(10);
    bus_addr = 4'h4; bus_wdata = 32'h8; bus_wen = 1'b1;
    tick(1);
    bus_wen = 1'b0;
    tick(6);
    rx_pin = 1'b1;
    tick(10);
    rd(4'h4, v); check("t5_ferr_set_wins", v, 32'h0000_0008);
    wr_status(32'h8);
    rd(4'h4, v); check("t5_ferr_cleared", v, 32'h0);

    // 6: reset mid-frame, then a good frame
    rx_pin = 1'b0;
    tick(16);
    rx_pin = 1'b1;
    tick(40);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(200);
    rd(4'h4, v); check("t6_status_after_rst", v, 32'h0);
    check("t6_irq_after_rst", {31'h0, rx_irq}, 32'h0);
    send_frame(8'h81);
    rd(4'h4, v); check("t6_status_frame", v, 32'h0000_0101);
    pop_check("t6_data", 32'h0000_0081);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
